button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Receives a raw, bouncing, asynchronous push-button level and produces a clean registered level.
- Also produces single-cycle press and release strobes for the downstream counter.
- Sits between the board pin and the counter enable; it is built from the team's flip-flop-style registers.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn_in (legal 2..4).
- TICK_DIV, 100000, clk cycles per sample tick (legal 1..2^24).
- STABLE_SAMPLES, 4, consecutive agreeing ticks required to accept a new level (legal 1..255).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- btn_in  input  1  raw asynchronous button level; no timing relationship to clk.
- level_out  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe when level_out goes 0->1.
- release_pulse  output  1  one-cycle strobe when level_out goes 1->0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Clears the synchronizer flops, tick counter, stable counter, FSM (to IDLE_LO), level_out, press_pulse and release_pulse, all to 0.
  - Reset wins over every other event.
  - Reset mid-confirmation discards partial progress; no pulse is emitted.
- Synchronizer: btn_in passes through SYNC_STAGES flops to give btn_s. No other logic reads btn_in.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle tick_cnt==TICK_DIV-1.
  - With TICK_DIV=1, tick is 1 every cycle.
  - The counter is free-running after reset and is not restarted by input activity.
- FSM states: IDLE_LO, CONFIRM_HI, IDLE_HI, CONFIRM_LO. Transitions are evaluated only on tick cycles; non-tick cycles hold state and stable_cnt.
  - IDLE_LO: btn_s==1 -> CONFIRM_HI with stable_cnt=1; else stay.
  - CONFIRM_HI:
    - btn_s==0 -> IDLE_LO with stable_cnt=0.
    - btn_s==1 and stable_cnt==STABLE_SAMPLES-1 -> IDLE_HI. On the same edge: level_out<=1, press_pulse<=1, stable_cnt<=0.
    - Otherwise stable_cnt+1.
  - IDLE_HI and CONFIRM_LO mirror the above with polarity inverted; acceptance sets release_pulse.
  - STABLE_SAMPLES=1: IDLE_x goes directly to IDLE_y on the first disagreeing tick; the CONFIRM states are unused.
- Pulses:
  - Registered and exactly 1 clk wide.
  - Deasserted on the next edge regardless of tick.
  - press_pulse and release_pulse are never both 1.
- level_out is registered; it changes only on the edge that also asserts the matching pulse.
- Widths: tick_cnt is clog2(TICK_DIV) bits (minimum 1); stable_cnt is 8 bits. Counters never exceed their terminal values.
- Latency, steady btn_in edge to pulse: between SYNC_STAGES+(STABLE_SAMPLES-1)*TICK_DIV+1 and SYNC_STAGES+STABLE_SAMPLES*TICK_DIV clk cycles, depending on tick phase.
- Glitch rejection: an input excursion shorter than (STABLE_SAMPLES-1)*TICK_DIV cycles never changes level_out.
- Held button: exactly one press_pulse while held, however long.

Decomposition:
- Shared package debounce_pkg holds:
  - FSM state typedef (2-bit enum: IDLE_LO, CONFIRM_HI, IDLE_HI, CONFIRM_LO).
  - Default constants for SYNC_STAGES/TICK_DIV/STABLE_SAMPLES.
  - clog2 helper.
- One sub-module: sync_chain (parameter STAGES, ports clk, reset, d, q).
  - Shift register of flops with the same synchronous active-low reset.
  - Reusable for other asynchronous board inputs.

Test Plan (SYNC_STAGES=2, TICK_DIV=4, STABLE_SAMPLES=3 unless noted):
- Reset: hold reset=0 for 5 cycles with btn_in=1 -> level_out=0, both pulses 0 throughout; after release, normal operation starts from IDLE_LO.
- Clean press: btn_in 0->1 and held -> press_pulse high for exactly 1 cycle, 11..14 cycles after the edge; level_out=1 on the same edge and stays 1; no further pulses over 200 cycles.
- Bounce: btn_in toggles every 3 cycles for 30 cycles, then settles at 1 -> no pulse during the bounce; exactly one press_pulse after settling, within 14 cycles of the last edge.
- Glitch: btn_in=1 for 5 cycles, then 0 -> level_out stays 0, no pulses.
- Release plus reset mid-confirm:
  - From level_out=1, drive btn_in=0, then assert reset for 1 cycle during CONFIRM_LO -> level_out=0, no release_pulse.
  - Repeat without reset -> exactly one release_pulse, level_out falls on the same edge.
- Corner (TICK_DIV=1, STABLE_SAMPLES=1): btn_in 0->1 -> press_pulse exactly 3 cycles after the edge; a 1-cycle btn_in glitch is accepted as a press/release pair, with pulses separated by at least 1 cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types, default parameter values and helpers for the button debouncer.
package debounce_pkg;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_TICK_DIV       = 100000;
  localparam int unsigned DEF_STABLE_SAMPLES = 4;

  // Debounce FSM: two settled levels, each with a confirmation state toward the other.
  typedef enum logic [1:0] {
    IDLE_LO    = 2'd0,
    CONFIRM_HI = 2'd1,
    IDLE_HI    = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  // Bits needed to hold 0..value-1, never less than one so a divide-by-1 still has a counter.
  function automatic int unsigned clog2_min1(input longint unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 40; i++) begin
      if ((64'd1 << i) < value) begin
        width = i + 1;
      end
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// Multi-flop synchronizer for an asynchronous level input; reusable for any board pin.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_shift;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Stage gi samples the previous stage (or the raw input for the first stage).
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_shift[gi] <= 1'b0;
        end else if (gi == 0) begin
          r_shift[gi] <= d;
        end else begin
          r_shift[gi] <= r_shift[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign q = r_shift[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw pin, samples it on a slow tick and
// only accepts a new level after enough consecutive agreeing samples.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned       TICK_W      = clog2_min1(longint'(TICK_DIV));
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        STABLE_LAST = 8'(STABLE_SAMPLES - 1);
  localparam bit                SINGLE_SAMPLE = (STABLE_SAMPLES == 1);

  logic              w_btn_s;
  logic              w_tick;
  logic [TICK_W-1:0] r_tick_cnt;
  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_stable_cnt;
  logic [7:0]        w_stable_next;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              w_level_next;
  logic              w_press_next;
  logic              w_release_next;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (w_btn_s)
  );

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running sample-tick divider; input activity never restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // State register and agreement counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE_LO;
      r_stable_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_stable_cnt <= w_stable_next;
    end
  end

  // Next-state logic; only tick cycles may move the FSM or the counter.
  always_comb begin
    w_state_next  = r_state;
    w_stable_next = r_stable_cnt;
    if (w_tick) begin
      case (r_state)
        IDLE_LO: begin
          if (w_btn_s) begin
            if (SINGLE_SAMPLE) begin
              w_state_next = IDLE_HI;
            end else begin
              w_state_next  = CONFIRM_HI;
              w_stable_next = 8'd1;
            end
          end
        end
        CONFIRM_HI: begin
          if (!w_btn_s) begin
            w_state_next  = IDLE_LO;
            w_stable_next = 8'd0;
          end else if (r_stable_cnt == STABLE_LAST) begin
            w_state_next  = IDLE_HI;
            w_stable_next = 8'd0;
          end else begin
            w_stable_next = r_stable_cnt + 8'd1;
          end
        end
        IDLE_HI: begin
          if (!w_btn_s) begin
            if (SINGLE_SAMPLE) begin
              w_state_next = IDLE_LO;
            end else begin
              w_state_next  = CONFIRM_LO;
              w_stable_next = 8'd1;
            end
          end
        end
        CONFIRM_LO: begin
          if (w_btn_s) begin
            w_state_next  = IDLE_HI;
            w_stable_next = 8'd0;
          end else if (r_stable_cnt == STABLE_LAST) begin
            w_state_next  = IDLE_LO;
            w_stable_next = 8'd0;
          end else begin
            w_stable_next = r_stable_cnt + 8'd1;
          end
        end
        default: begin
          w_state_next  = IDLE_LO;
          w_stable_next = 8'd0;
        end
      endcase
    end
  end

  // Output decode: a pulse fires only when the accepted level actually flips.
  always_comb begin
    w_press_next   = (w_state_next == IDLE_HI) &&
                     ((r_state == IDLE_LO) || (r_state == CONFIRM_HI));
    w_release_next = (w_state_next == IDLE_LO) &&
                     ((r_state == IDLE_HI) || (r_state == CONFIRM_LO));
    w_level_next   = r_level;
    if (w_press_next) begin
      w_level_next = 1'b1;
    end else if (w_release_next) begin
      w_level_next = 1'b0;
    end
  end

  // Registered outputs; pulses self-clear on the following edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  assign level_out     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a slow-tick instance (2/4/3) and a fast corner instance (2/1/1).
// Expected pulses are queued with their allowed edge window as stimulus is applied.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b1;
  logic btn_c = 1'b0;
  logic level_out, press_pulse, release_pulse;
  logic level_c, press_c, release_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rst_edge = 1'b1;
  bit prev_main = 1'b0;
  bit prev_c = 1'b0;

  typedef struct {
    bit is_press;
    int lo;
    int hi;
  } exp_t;

  exp_t q_main[$];
  exp_t q_c[$];

  button_debouncer #(.SYNC_STAGES(2), .TICK_DIV(4), .STABLE_SAMPLES(3)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  button_debouncer #(.SYNC_STAGES(2), .TICK_DIV(1), .STABLE_SAMPLES(1)) dut_c (
    .clk(clk), .reset(reset), .btn_in(btn_c),
    .level_out(level_c), .press_pulse(press_c), .release_pulse(release_c)
  );

  always #5 clk = ~clk;

  // Edge counter and whether reset was applied at the latest edge.
  always @(posedge clk) begin
    cyc++;
    rst_edge = !reset;
  end

  // Scoreboard for the main instance: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
      total++; bad++;
      $display("FAIL both_pulses_main: press=1 release=1 at cyc %0d, required at most one", cyc);
    end
    if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
      total++;
      if (q_main.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse_main: press=%0b release=%0b at cyc %0d, required none",
                 press_pulse, release_pulse, cyc);
      end else begin
        e = q_main.pop_front();
        if (e.is_press !== press_pulse || cyc < e.lo || cyc > e.hi) begin
          bad++;
          $display("FAIL pulse_main: press=%0b at cyc %0d, required press=%0b in [%0d,%0d]",
                   press_pulse, cyc, e.is_press, e.lo, e.hi);
        end else begin
          $display("pulse_main ok: press=%0b at cyc %0d", press_pulse, cyc);
        end
      end
    end
    if (!rst_edge && level_out !== prev_main) begin
      total++;
      if (level_out ? (press_pulse !== 1'b1) : (release_pulse !== 1'b1)) begin
        bad++;
        $display("FAIL level_edge_main: level=%0b press=%0b release=%0b at cyc %0d, required matching pulse",
                 level_out, press_pulse, release_pulse, cyc);
      end
    end
    prev_main = level_out;
  end

  // Scoreboard for the corner instance.
  always @(negedge clk) begin
    exp_t e;
    if (press_c === 1'b1 && release_c === 1'b1) begin
      total++; bad++;
      $display("FAIL both_pulses_corner: press=1 release=1 at cyc %0d, required at most one", cyc);
    end
    if (press_c === 1'b1 || release_c === 1'b1) begin
      total++;
      if (q_c.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse_corner: press=%0b release=%0b at cyc %0d, required none",
                 press_c, release_c, cyc);
      end else begin
        e = q_c.pop_front();
        if (e.is_press !== press_c || cyc < e.lo || cyc > e.hi) begin
          bad++;
          $display("FAIL pulse_corner: press=%0b at cyc %0d, required press=%0b in [%0d,%0d]",
                   press_c, cyc, e.is_press, e.lo, e.hi);
        end else begin
          $display("pulse_corner ok: press=%0b at cyc %0d", press_c, cyc);
        end
      end
    end
    if (!rst_edge && level_c !== prev_c) begin
      total++;
      if (level_c ? (press_c !== 1'b1) : (release_c !== 1'b1)) begin
        bad++;
        $display("FAIL level_edge_corner: level=%0b press=%0b release=%0b at cyc %0d, required matching pulse",
                 level_c, press_c, release_c, cyc);
      end
    end
    prev_c = level_c;
  end

  task automatic test_reset();
    int t0;
    reset = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (level_out !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: level=%0b press=%0b release=%0b, required 0/0/0",
                 level_out, press_pulse, release_pulse);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b1, lo: t0 + 11, hi: t0 + 14});
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b1 || q_main.size() != 0) begin
      bad++;
      $display("FAIL reset_then_press: level=%0b pending=%0d, required level=1 pending=0",
               level_out, q_main.size());
    end
    $display("test_reset done at cyc %0d", cyc);
  endtask

  task automatic test_release_reset();
    int t0;
    // Release, interrupted by reset while confirming the low level.
    @(posedge clk); #1;
    btn_in = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (level_out !== 1'b0 || release_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_confirm: level=%0b release=%0b, required 0/0", level_out, release_pulse);
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_level: level=%0b, required 0", level_out);
    end
    // Press again, then release without reset.
    @(posedge clk); #1;
    btn_in = 1'b1;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b1, lo: t0 + 11, hi: t0 + 14});
    repeat (20) @(posedge clk);
    @(posedge clk); #1;
    btn_in = 1'b0;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b0, lo: t0 + 11, hi: t0 + 14});
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b0 || q_main.size() != 0) begin
      bad++;
      $display("FAIL release_clean: level=%0b pending=%0d, required level=0 pending=0",
               level_out, q_main.size());
    end
    $display("test_release_reset done at cyc %0d", cyc);
  endtask

  task automatic test_clean_press();
    int t0;
    @(posedge clk); #1;
    btn_in = 1'b1;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b1, lo: t0 + 11, hi: t0 + 14});
    repeat (200) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b1 || q_main.size() != 0) begin
      bad++;
      $display("FAIL clean_press_hold: level=%0b pending=%0d, required level=1 pending=0",
               level_out, q_main.size());
    end
    @(posedge clk); #1;
    btn_in = 1'b0;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b0, lo: t0 + 11, hi: t0 + 14});
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b0 || q_main.size() != 0) begin
      bad++;
      $display("FAIL clean_release: level=%0b pending=%0d, required level=0 pending=0",
               level_out, q_main.size());
    end
    $display("test_clean_press done at cyc %0d", cyc);
  endtask

  task automatic test_bounce();
    int t0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      btn_in = (i % 2 == 0);
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    total++;
    if (level_out !== 1'b0) begin
      bad++;
      $display("FAIL bounce_level: level=%0b, required 0", level_out);
    end
    @(posedge clk); #1;
    btn_in = 1'b1;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b1, lo: t0 + 1, hi: t0 + 14});
    repeat (25) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b1 || q_main.size() != 0) begin
      bad++;
      $display("FAIL bounce_settle: level=%0b pending=%0d, required level=1 pending=0",
               level_out, q_main.size());
    end
    @(posedge clk); #1;
    btn_in = 1'b0;
    t0 = cyc;
    q_main.push_back('{is_press: 1'b0, lo: t0 + 11, hi: t0 + 14});
    repeat (20) @(posedge clk);
    $display("test_bounce done at cyc %0d", cyc);
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    btn_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 btn_in = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_out !== 1'b0 || q_main.size() != 0) begin
      bad++;
      $display("FAIL glitch: level=%0b pending=%0d, required level=0 pending=0",
               level_out, q_main.size());
    end
    $display("test_glitch done at cyc %0d", cyc);
  endtask

  task automatic test_corner();
    int t0;
    @(posedge clk); #1;
    btn_c = 1'b1;
    t0 = cyc;
    q_c.push_back('{is_press: 1'b1, lo: t0 + 3, hi: t0 + 3});
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_c !== 1'b1 || q_c.size() != 0) begin
      bad++;
      $display("FAIL corner_press: level=%0b pending=%0d, required level=1 pending=0",
               level_c, q_c.size());
    end
    @(posedge clk); #1;
    btn_c = 1'b0;
    t0 = cyc;
    q_c.push_back('{is_press: 1'b0, lo: t0 + 3, hi: t0 + 3});
    repeat (6) @(posedge clk);
    // One-cycle glitch is accepted as a press/release pair.
    @(posedge clk); #1;
    btn_c = 1'b1;
    t0 = cyc;
    q_c.push_back('{is_press: 1'b1, lo: t0 + 3, hi: t0 + 3});
    q_c.push_back('{is_press: 1'b0, lo: t0 + 4, hi: t0 + 4});
    @(posedge clk); #1;
    btn_c = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++;
    if (level_c !== 1'b0 || q_c.size() != 0) begin
      bad++;
      $display("FAIL corner_glitch: level=%0b pending=%0d, required level=0 pending=0",
               level_c, q_c.size());
    end
    $display("test_corner done at cyc %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_release_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
